// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage controller between the pipeline and a
// word-addressed, synchronous-read data memory. Performs byte/half/word
// loads with sign/zero extension and read-modify-write for sub-word stores.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised the payload must stay stable until that
// edge. req_ready is high only in IDLE. resp_valid, resp_data and resp_err
// stay stable until resp_ready is sampled high.
module load_store_unit #(
  parameter int MEM_IDX_W   = 16,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_we,
  input  logic [1:0]           i_req_size,
  input  logic                 i_req_signed,
  input  logic [31:0]          i_req_addr,
  input  logic [31:0]          i_req_wdata,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic [31:0]          o_resp_data,
  output logic                 o_resp_err,
  output logic                 o_mem_rd,
  output logic                 o_mem_wrt,
  output logic [31:0]          o_mem_addr,
  output logic [31:0]          o_mem_wdata,
  input  logic [31:0]          i_mem_rdata,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_we;
  logic [1:0]             r_size;
  logic                   r_signed;
  logic [1:0]             r_off;
  logic [MEM_IDX_W-1:0]   r_idx;
  logic [15:0]            r_wdata;
  logic [31:0]            r_mem_wdata;
  logic [31:0]            r_resp_data;
  logic                   r_resp_err;

  logic                   w_accept;
  logic                   w_err;
  logic                   w_range_err;
  logic [31:0]            w_hi_bits;
  logic                   w_word_store;
  logic [31:0]            w_shifted;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [31:0]            w_load_data;
  logic [31:0]            w_merged;

  // Request decode: acceptance, error classification, word-store shortcut
  always_comb begin
    w_accept     = i_req_valid && (r_state == S_IDLE);
    w_hi_bits    = i_req_addr >> (MEM_IDX_W + 2);
    w_range_err  = CHECK_RANGE && (w_hi_bits != 32'd0);
    w_err        = (i_req_size == 2'b11) ||
                   ((i_req_size == SZ_HALF) && i_req_addr[0]) ||
                   ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00)) ||
                   w_range_err;
    w_word_store = i_req_we && (i_req_size == SZ_WORD);
  end

  // Lane selection with extension for loads, lane merge for sub-word stores
  always_comb begin
    w_shifted   = i_mem_rdata >> {r_off, 3'b000};
    w_byte      = w_shifted[7:0];
    w_half      = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    w_load_data = i_mem_rdata;
    w_merged    = i_mem_rdata;
    case (r_size)
      SZ_BYTE: begin
        w_load_data = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
        w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
      end
      SZ_HALF: begin
        w_load_data = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        if (r_off[1]) w_merged[31:16] = r_wdata;
        else          w_merged[15:0]  = r_wdata;
      end
      default: begin
        w_load_data = i_mem_rdata;
        w_merged    = i_mem_rdata;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)             w_next = S_RESP;
          else if (w_word_store) w_next = S_WRITE;
          else                   w_next = S_READ;
        end
      end
      S_READ:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = r_we ? S_WRITE : S_RESP;
      S_WRITE:   w_next = S_RESP;
      S_RESP:    if (i_resp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request latch, merged store word and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_off       <= 2'b00;
      r_idx       <= '0;
      r_wdata     <= 16'd0;
      r_mem_wdata <= 32'd0;
      r_resp_data <= 32'd0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we        <= i_req_we;
        r_size      <= i_req_size;
        r_signed    <= i_req_signed;
        r_off       <= i_req_addr[1:0];
        r_idx       <= i_req_addr[MEM_IDX_W+1:2];
        r_wdata     <= i_req_wdata[15:0];
        r_resp_data <= 32'd0;
        r_resp_err  <= w_err;
        if (w_word_store && !w_err) r_mem_wdata <= i_req_wdata;
      end else if (r_state == S_CAPTURE) begin
        if (r_we) r_mem_wdata <= w_merged;
        else      r_resp_data <= w_load_data;
      end
    end
  end

  // Memory strobes come straight from the state so they can never overlap
  assign o_mem_rd     = (r_state == S_READ);
  assign o_mem_wrt    = (r_state == S_WRITE);
  assign o_mem_addr   = {{(32-MEM_IDX_W){1'b0}}, r_idx};
  assign o_mem_wdata  = r_mem_wdata;
  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_data  = r_resp_data;
  assign o_resp_err   = r_resp_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed tests for load_store_unit against a small
// synchronous-read memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_rd;
  logic        mem_wrt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [2:0]  dbg_state;

  int checks;
  int failures;

  // memory model and strobe bookkeeping
  logic [31:0] mem [0:255];
  int          rd_cnt;
  int          wrt_cnt;
  int          both_cnt;
  logic [31:0] last_wrt_addr;

  load_store_unit #(.MEM_IDX_W(16), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_signed(req_signed),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_data(resp_data), .o_resp_err(resp_err),
    .o_mem_rd(mem_rd), .o_mem_wrt(mem_wrt), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem_rdata     = 32'd0;
    rd_cnt        = 0;
    wrt_cnt       = 0;
    both_cnt      = 0;
    last_wrt_addr = 32'd0;
  end

  always @(posedge clk) begin
    if (mem_wrt) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wrt_cnt++;
      last_wrt_addr <= mem_addr;
    end
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr[7:0]];
      rd_cnt++;
    end
    if (mem_rd && mem_wrt) both_cnt++;
  end

  // driver tasks
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output logic [31:0] data, output logic err);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    data = resp_data;
    err  = resp_err;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    checks++; if (resp_data !== 32'd0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
    checks++; if ({mem_rd, mem_wrt} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_rd, mem_wrt}); end
    checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_word_store_load();
    int lat; logic [31:0] d; logic e; int wc; int rc;
    wc = wrt_cnt; rc = rd_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    wait_resp(lat, d, e);
    checks++; if (lat !== 2) begin failures++; $display("FAIL wst_latency got=%0d exp=2", lat); end
    checks++; if ({e, d} !== 33'd0) begin failures++; $display("FAIL wst_resp got=%b/%h exp=0/0", e, d); end
    ack();
    checks++; if (wrt_cnt - wc !== 1 || rd_cnt - rc !== 0) begin failures++; $display("FAIL wst_strobes got=wrt%0d/rd%0d exp=1/0", wrt_cnt - wc, rd_cnt - rc); end
    checks++; if (last_wrt_addr !== 32'd4) begin failures++; $display("FAIL wst_mem_addr got=%h exp=4", last_wrt_addr); end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    wait_resp(lat, d, e);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wld_latency got=%0d exp=3", lat); end
    checks++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin failures++; $display("FAIL wld_data got=%h/%b exp=deadbeef/0", d, e); end
    ack();
  endtask

  task automatic test_subword_store();
    int lat; logic [31:0] d; logic e; int wc; int rc;
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    wait_resp(lat, d, e); ack();
    wc = wrt_cnt; rc = rd_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
    wait_resp(lat, d, e);
    checks++; if (lat !== 4) begin failures++; $display("FAIL bst_latency got=%0d exp=4", lat); end
    ack();
    checks++; if (wrt_cnt - wc !== 1 || rd_cnt - rc !== 1) begin failures++; $display("FAIL bst_strobes got=wrt%0d/rd%0d exp=1/1", wrt_cnt - wc, rd_cnt - rc); end
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    wait_resp(lat, d, e);
    checks++; if (d !== 32'h1122AA44 || e !== 1'b0) begin failures++; $display("FAIL bst_merge got=%h/%b exp=1122aa44/0", d, e); end
    ack();
  endtask

  task automatic test_load_extend();
    int lat; logic [31:0] d; logic e;
    logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [4] = '{32'h2, 32'h3, 32'h2, 32'h0};
    logic [31:0] exp_d [4] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h80FF7F01);
    wait_resp(lat, d, e); ack();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sz[i], sg[i], ad[i], 32'd0);
      wait_resp(lat, d, e);
      checks++; if (d !== exp_d[i] || e !== 1'b0) begin failures++; $display("FAIL ext_load%0d got=%h/%b exp=%h/0", i, d, e, exp_d[i]); end
      ack();
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] d; logic e; int wc; int rc;
    logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] ad [4] = '{32'h1, 32'h6, 32'h8, 32'h00040000};
    wc = wrt_cnt; rc = rd_cnt;
    for (int i = 0; i < 4; i++) begin
      issue(we[i], sz[i], 1'b0, ad[i], 32'h12345678);
      wait_resp(lat, d, e);
      checks++; if (lat !== 1 || e !== 1'b1 || d !== 32'd0) begin failures++; $display("FAIL err_case%0d got=lat%0d/%b/%h exp=lat1/1/0", i, lat, e, d); end
      ack();
    end
    checks++; if (wrt_cnt - wc !== 0 || rd_cnt - rc !== 0) begin failures++; $display("FAIL err_no_mem got=wrt%0d/rd%0d exp=0/0", wrt_cnt - wc, rd_cnt - rc); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] d; logic e; int bad;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    wait_resp(lat, d, e);
    bad = 0;
    // offer a competing request while held; it must be ignored
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF || req_ready !== 1'b0) bad++;
    end
    req_valid = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d_bad_cycles exp=0", bad); end
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_data got=%h exp=deadbeef", d); end
    ack();
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=rdy%b/vld%b exp=1/0", req_ready, resp_valid); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_ignored_req got=%h exp=deadbeef", mem[4]); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] d; logic e; int wc;
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344);
    wait_resp(lat, d, e); ack();
    wc = wrt_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h00000055);
    @(posedge clk); #1;
    checks++; if (dbg_state !== 3'd2) begin failures++; $display("FAIL rst_mid_in_capture got=%0d exp=2", dbg_state); end
    rst_n = 1'b0;
    #2;
    checks++; if ({resp_valid, resp_err, mem_rd, mem_wrt} !== 4'b0000 || resp_data !== 32'd0 ||
                  mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      failures++; $display("FAIL rst_mid_outputs got=%b/%h/%h/%h exp=0000/0/0/0",
                           {resp_valid, resp_err, mem_rd, mem_wrt}, resp_data, mem_addr, mem_wdata);
    end
    #1; rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (wrt_cnt - wc !== 0) begin failures++; $display("FAIL rst_mid_no_write got=%0d exp=0", wrt_cnt - wc); end
    checks++; if (mem[12] !== 32'h11223344) begin failures++; $display("FAIL rst_mid_word got=%h exp=11223344", mem[12]); end
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'd0);
    wait_resp(lat, d, e);
    checks++; if (lat !== 3 || d !== 32'h11223344 || e !== 1'b0) begin failures++; $display("FAIL rst_mid_next got=lat%0d/%h/%b exp=lat3/11223344/0", lat, d, e); end
    ack();
  endtask

  task automatic test_no_overlap();
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    checks = 0; failures = 0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0; rst_n = 1'b0;
    test_reset();
    test_word_store_load();
    test_subword_store();
    test_load_extend();
    test_errors();
    test_backpressure();
    test_reset_mid_op();
    test_no_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
